// File: rtl/bip_accumulator.sv
// Accumulator/ALU stage of the BIP datapath.
// Accepts one operation per handshake, executes it in a single EXEC cycle,
// then retires it with a registered done pulse. HLT parks the block in HALT
// until reset.
module bip_accumulator #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] operand,
    output logic              op_ready,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] store_data,
    output logic              store_we,
    output logic              done,
    output logic              halted,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v
);

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LD  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_STO = 3'd4;
    localparam logic [2:0] OP_HLT = 3'd5;

    localparam int MSB = DATA_W - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   opnd_q;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                z_q, z_d;
    logic                n_q, n_d;
    logic                v_q, v_d;
    logic                done_q;
    logic [DATA_W-1:0]   sum, diff;
    logic                accept;

    assign accept = (state_q == S_IDLE) && op_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake/strobe outputs, all decoded from the state register
    always_comb begin
        state_d  = state_q;
        op_ready = 1'b0;
        store_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) state_d = S_EXEC;
            end
            S_EXEC: begin
                store_we = (op_q == OP_STO);
                state_d  = (op_q == OP_HLT) ? S_HALT : S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the operation at acceptance; EXEC works only from these copies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_NOP;
            opnd_q <= '0;
        end else if (accept) begin
            op_q   <= op_code;
            opnd_q <= operand;
        end
    end

    assign sum  = acc_q + opnd_q;
    assign diff = acc_q - opnd_q;

    // ALU: result and flags computed for the op held in EXEC; carry is dropped
    always_comb begin
        acc_d = acc_q;
        z_d   = z_q;
        n_d   = n_q;
        v_d   = v_q;
        if (state_q == S_EXEC) begin
            case (op_q)
                OP_LD: begin
                    acc_d = opnd_q;
                    z_d   = (opnd_q == '0);
                    n_d   = opnd_q[MSB];
                    v_d   = 1'b0;
                end
                OP_ADD: begin
                    acc_d = sum;
                    z_d   = (sum == '0);
                    n_d   = sum[MSB];
                    v_d   = (acc_q[MSB] == opnd_q[MSB]) && (sum[MSB] != acc_q[MSB]);
                end
                OP_SUB: begin
                    acc_d = diff;
                    z_d   = (diff == '0);
                    n_d   = diff[MSB];
                    v_d   = (acc_q[MSB] != opnd_q[MSB]) && (diff[MSB] != acc_q[MSB]);
                end
                default: ;  // STO, HLT, NOP and spare codes leave acc/flags alone
            endcase
        end
    end

    // Accumulator, flags and the retire pulse that follows every EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            z_q    <= z_d;
            n_q    <= n_d;
            v_q    <= v_d;
            done_q <= (state_q == S_EXEC);
        end
    end

    assign acc        = acc_q;
    assign store_data = acc_q;
    assign done       = done_q;
    assign halted     = (state_q == S_HALT);
    assign flag_z     = z_q;
    assign flag_n     = n_q;
    assign flag_v     = v_q;

endmodule

// File: tb/tb_bip_accumulator.sv
// Scoreboard bench for bip_accumulator: expected acc/flags are pushed when an
// operation is accepted and popped when the DUT pulses done.
module tb_bip_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [15:0] operand = 16'h0;
    logic        op_ready;
    logic [15:0] acc;
    logic [15:0] store_data;
    logic        store_we;
    logic        done;
    logic        halted;
    logic        flag_z, flag_n, flag_v;

    bip_accumulator #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .operand    (operand),
        .op_ready   (op_ready),
        .acc        (acc),
        .store_data (store_data),
        .store_we   (store_we),
        .done       (done),
        .halted     (halted),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_v     (flag_v)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int store_cnt = 0;
    int done_cnt = 0;
    int n_ops = 0;
    logic [31:0] exp_q[$];

    logic [15:0] m_acc = 16'h0;
    logic        m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference model: signed arithmetic in 32 bits, overflow = out of 16-bit range
    task automatic model_apply(input logic [2:0] code, input logic [15:0] b);
        int sa, sb, si;
        logic [15:0] r;
        sa = $signed(m_acc);
        sb = $signed(b);
        case (code)
            3'd1: begin
                m_acc = b; m_z = (b == 16'h0); m_n = b[15]; m_v = 1'b0;
            end
            3'd2, 3'd3: begin
                si = (code == 3'd2) ? sa + sb : sa - sb;
                r  = si[15:0];
                m_v = (si > 32767) || (si < -32768);
                m_acc = r; m_z = (r == 16'h0); m_n = r[15];
            end
            default: ;
        endcase
    endtask

    // Monitor: count strobes, pop one expectation per done pulse
    always @(negedge clk) begin
        logic [31:0] e;
        if (store_we === 1'b1) store_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("done_result", {13'b0, acc, flag_z, flag_n, flag_v}, e);
            end
        end
    end

    // Issue one op; hold=1 keeps op_valid high and scrambles inputs during EXEC
    task automatic do_op(input logic [2:0] code, input logic [15:0] opnd, input bit hold);
        logic [15:0] pre;
        @(negedge clk);
        op_valid = 1'b1; op_code = code; operand = opnd;
        @(posedge clk); #1;
        pre = m_acc;
        model_apply(code, opnd);
        exp_q.push_back({13'b0, m_acc, m_z, m_n, m_v});
        n_ops++;
        if (hold) begin
            operand = ~opnd; op_code = 3'd2;
        end else op_valid = 1'b0;
        @(negedge clk);
        chk("exec_ready", {31'b0, op_ready}, 32'd0);
        chk("exec_we", {31'b0, store_we}, {31'b0, code == 3'd4});
        if (code == 3'd4) chk("store_data", {16'b0, store_data}, {16'b0, pre});
        @(negedge clk);
        op_valid = 1'b0;
        chk("post_ready", {31'b0, op_ready}, {31'b0, code != 3'd5});
        chk("post_we", {31'b0, store_we}, 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_acc"},   {16'b0, acc}, 32'd0);
        chk({tag, "_flags"}, {29'b0, flag_z, flag_n, flag_v}, 32'd0);
        chk({tag, "_we"},    {31'b0, store_we}, 32'd0);
        chk({tag, "_done"},  {31'b0, done}, 32'd0);
        chk({tag, "_halt"},  {31'b0, halted}, 32'd0);
    endtask

    initial begin
        int s0;
        repeat (2) @(negedge clk);
        check_reset("rst0");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst0_ready", {31'b0, op_ready}, 32'd1);

        // Basic load/add
        do_op(3'd1, 16'h0005, 0);
        do_op(3'd2, 16'h0003, 0);
        // Positive overflow, then zero result
        do_op(3'd1, 16'h7FFF, 0);
        do_op(3'd2, 16'h0001, 0);
        do_op(3'd1, 16'h0003, 0);
        do_op(3'd3, 16'h0003, 0);
        // 0x8000 + 0x8000 and 0x8000 - 1
        do_op(3'd1, 16'h8000, 0);
        do_op(3'd2, 16'h8000, 0);
        do_op(3'd1, 16'h8000, 0);
        do_op(3'd3, 16'h0001, 0);
        // Store: one strobe, acc/flags unchanged
        do_op(3'd1, 16'h1234, 0);
        s0 = store_cnt;
        do_op(3'd4, 16'hBEEF, 0);
        chk("sto_count", store_cnt - s0, 32'd1);
        // Inputs wiggling during EXEC are ignored
        do_op(3'd1, 16'h0042, 1);
        do_op(3'd2, 16'h0100, 1);
        do_op(3'd6, 16'hFFFF, 0);
        do_op(3'd7, 16'h1111, 0);
        do_op(3'd0, 16'h2222, 0);

        // Reset during STO EXEC: strobe drops at once, no done
        do_op(3'd1, 16'h5555, 0);
        s0 = store_cnt;
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd4; operand = 16'h0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("sto_exec_we", {31'b0, store_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we_drop", {31'b0, store_we}, 32'd0);
        m_acc = 16'h0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst1");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst1_nostore", store_cnt - s0, 32'd0);
        chk("rst1_ready", {31'b0, op_ready}, 32'd1);

        // Halt, then a held LD is ignored
        do_op(3'd1, 16'hA5A5, 0);
        s0 = store_cnt;
        do_op(3'd5, 16'h0000, 0);
        op_valid = 1'b1; op_code = 3'd1; operand = 16'h00FF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_flag", {31'b0, halted}, 32'd1);
            chk("halt_ready", {31'b0, op_ready}, 32'd0);
        end
        op_valid = 1'b0;
        chk("halt_acc", {16'b0, acc}, {16'b0, m_acc});
        chk("halt_flags", {29'b0, flag_z, flag_n, flag_v}, {29'b0, m_z, m_n, m_v});
        chk("halt_nostore", store_cnt - s0, 32'd0);

        // Reset is the only way out of HALT
        rst_n = 1'b0;
        #1;
        check_reset("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_ready", {31'b0, op_ready}, 32'd1);
        repeat (2) @(negedge clk);

        chk("queue_empty", exp_q.size(), 32'd0);
        chk("done_count", done_cnt, n_ops);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bip_accumulator.md
Name: bip_accumulator

Overview:
Accumulator/ALU stage of the BIP datapath. It sits directly downstream of the 16-bit operand multiplexer, which selects between the data-memory read value and the sign-extended immediate. It consumes the selected operand under a valid/ready handshake and executes LD/ADD/SUB/STO/NOP/HLT on the accumulator. It produces the accumulator, the status flags, a store strobe toward data memory and a completion pulse for the control unit.

Parameters:
DATA_W, 16, operand/accumulator width in bits; all arithmetic is modulo 2^DATA_W.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous reset, active low
op_valid  input  1  control unit presents an operation
op_code  input  3  0 NOP, 1 LD, 2 ADD, 3 SUB, 4 STO, 5 HLT; 6 and 7 are treated as NOP
operand  input  DATA_W  selected operand from the operand mux
op_ready  output  1  block can accept an operation this cycle
acc  output  DATA_W  accumulator register
store_data  output  DATA_W  value to write to data memory (equals acc)
store_we  output  1  data-memory write strobe, one cycle
done  output  1  one-cycle pulse, operation retired
halted  output  1  HLT executed
flag_z  output  1  result zero
flag_n  output  1  result MSB
flag_v  output  1  signed overflow

Behaviour:
- Clock and reset: one clock, clk. Asynchronous active-low reset on rst_n.
- Reset (asynchronous, immediate on rst_n=0):
  - acc=0, flags=0, store_we=0, done=0, halted=0.
  - State goes to IDLE, so op_ready=1 after release.
  - Internal op/operand registers are cleared.
- States: IDLE, EXEC, HALT.
  - op_ready = (state==IDLE). It is combinational from the state register.
- IDLE:
  - On op_valid && op_ready at an edge: latch op_code into op_r and operand into opnd_r, then go to EXEC.
  - If op_valid=0: remain in IDLE with no change.
- EXEC (exactly one cycle):
  - At the edge ending EXEC, op_r is applied:
    - LD: acc<=opnd_r; Z/N from opnd_r; V<=0.
    - ADD: acc<=acc+opnd_r; V<=(acc[MSB]==opnd_r[MSB]) && (sum[MSB]!=acc[MSB]).
    - SUB: acc<=acc-opnd_r; V<=(acc[MSB]!=opnd_r[MSB]) && (diff[MSB]!=acc[MSB]).
    - ADD and SUB also set Z=(result==0) and N=result[MSB].
    - STO: acc and flags unchanged.
    - NOP, 6, 7: no change.
  - Carry out of ADD/SUB is discarded (wrap-around).
  - After EXEC, the next state is IDLE, except for HLT, which goes to HALT.
- store_we:
  - Asserted combinationally during the EXEC cycle when op_r==STO, else 0.
  - store_data = acc at all times, so during a STO it is the pre-STO acc.
- done:
  - Registered. It is 1 for the single cycle following the EXEC-ending edge, for every opcode including HLT.
  - acc and flags are already updated in the cycle done=1.
- Timing:
  - Latency: acceptance edge T; result visible in acc at edge T+1; done high in cycle T+1..T+2.
  - Throughput: one operation per 2 cycles.
  - The next op can be accepted at edge T+2, since op_ready is high again in the cycle after EXEC.
- HALT:
  - halted=1 and op_ready=0 permanently. op_valid is ignored.
  - acc and flags are frozen.
  - The only exit is rst_n.
- Boundary conditions:
  - op_valid asserted while op_ready=0 (EXEC or HALT): no latch, no side effect; the control unit must hold it.
  - operand and op_code changing during EXEC have no effect (the latched copies are used).
  - Reset asserted during EXEC of a STO: store_we drops immediately and no write completes; done is not produced.
  - ADD 0x8000+0x8000: acc=0x0000, Z=1, N=0, V=1.
  - SUB 0x8000-0x0001: acc=0x7FFF, V=1.

Test Plan:
- Reset check: hold rst_n=0 mid-run, then release -> acc=0x0000, flags 000, store_we=0, done=0, halted=0, op_ready=1.
- LD 0x0005 then ADD 0x0003 -> acc=0x0005 then 0x0008; one done pulse per op; Z=N=V=0; op_ready low only during each EXEC cycle.
- LD 0x7FFF, ADD 0x0001 -> acc=0x8000, N=1, V=1, Z=0. Then LD 0x0003, SUB 0x0003 -> acc=0x0000, Z=1, N=0, V=0.
- LD 0x1234, STO -> store_we high exactly one cycle with store_data=0x1234; acc stays 0x1234; flags unchanged.
- HLT, then LD 0x00FF held valid 10 cycles -> done pulses once for HLT; halted=1, op_ready=0; acc unchanged; no store_we.
- Other checks:
  - op_valid held high with varying operand during EXEC -> only the acceptance-cycle operand is used.
  - Assert rst_n=0 during a STO EXEC -> store_we falls the same cycle; done never pulses.
